instr_fetch_unit: RTL and testbench

- Front-end stage upstream of the single-cycle decode/execute core; replaces the direct combinational instruction-memory read.
- Fetches 16-bit instructions in order from a multi-cycle, handshaked instruction memory and buffers them in a small FIFO.
- Presents instructions to decode over a valid/ready interface.
- Handles branch/jump redirects, wrong-path flushes and HLT freeze.

---
 rtl/instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Front-end fetch stage. Reads 16-bit instruction words in order from a
//   multi-cycle, handshaked instruction memory (one request outstanding at a
//   time), buffers them in a DEPTH-entry FIFO and hands them to decode.
//   Handles redirects from execute, wrong-path discards and the HLT freeze.
//
// Optional feature: define FETCH_PERF_EN to add the flush_cnt / stall_cnt
//   saturating performance counters and their output ports.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_req/mem_addr         read request and word address (held until mem_gnt)
//   mem_gnt                  memory accepted the request this cycle
//   mem_rvalid/mem_rdata     read data returned, in request order
//   instr_valid/instr_ready  decode handshake: the head word (instr, instr_pc)
//                            transfers in every cycle where both are high;
//                            instr_valid never depends on instr_ready
//   redirect/redirect_pc     new fetch address from execute
//   hlt_seen                 decode consumed an HLT; freeze fetch
//   halted                   fetch is frozen until reset
//   flush_cnt, stall_cnt     (FETCH_PERF_EN only) performance counters

module instr_fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              hlt_seen,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_e;

    // state_q is the FSM state visible to checkers bound on this module.
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              discard_q, discard_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       word_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];

    logic is_halted, hlt_eff, redirect_eff, flush, push, pop;

    // HLT outranks redirect, and neither does anything once frozen.
    assign is_halted    = (state_q == HALT);
    assign hlt_eff      = hlt_seen & ~is_halted;
    assign redirect_eff = redirect & ~is_halted & ~hlt_seen;
    assign flush        = hlt_eff | redirect_eff;

    // Only a WAIT-state return that is not on the wrong path enters the queue.
    assign push = (state_q == WAIT) & mem_rvalid & ~discard_q & ~flush;
    assign pop  = instr_valid & instr_ready & ~flush;

    assign instr_valid = (count_q != '0);
    assign instr       = word_q[rd_ptr_q];
    assign instr_pc    = addr_q[rd_ptr_q];
    assign halted      = is_halted;
    assign mem_req     = (state_q == REQ);
    assign mem_addr    = fetch_pc_q;

    // Queue pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch FSM. A new request is only started when the queue can take its
    // word, so a return never finds the queue full.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        case (state_q)
            IDLE: if (count_q < DEPTH_CNT) state_d = REQ;
            REQ: begin
                if (mem_gnt) begin
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    discard_d = 1'b0;
                    state_d   = (count_d < DEPTH_CNT) ? REQ : IDLE;
                end
            end
            default: state_d = HALT;
        endcase

        if (hlt_eff) begin
            // Any word still in flight returns while in HALT and is ignored.
            state_d   = HALT;
            discard_d = 1'b0;
        end else if (redirect_eff) begin
            fetch_pc_d = redirect_pc;
            case (state_q)
                REQ: begin
                    if (mem_gnt) begin
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end
                end
                default: begin
                    discard_d = 1'b0;
                    state_d   = REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            req_addr_q <= '0;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (push) begin
            word_q[wr_ptr_q] <= mem_rdata;
            addr_q[wr_ptr_q] <= req_addr_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (redirect_eff && (count_q != '0 || state_q == WAIT) && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
        if (!instr_valid && !is_halted && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: behavioural instruction memory returning
// rdata = addr + 0x1000 after a programmable latency, and a scoreboard of
// expected {instr, instr_pc} words checked on every decode transfer.

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        hlt_seen;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Memory model state
    int          rd_lat = 1;
    logic        pend   = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_data = '0;
    int          grant_cnt = 0;
    logic [15:0] last_gnt_addr = 16'hFFFF;

    instr_fetch_unit #(.DEPTH(4), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .hlt_seen    (hlt_seen),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .flush_cnt   (flush_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model (decides on the falling edge) ----------------
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pend       = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        mem_gnt = rst_n && mem_req;
        if (mem_gnt) begin
            pend          = 1'b1;
            pend_cnt      = rd_lat;
            pend_data     = mem_addr + 16'h1000;
            grant_cnt++;
            last_gnt_addr = mem_addr;
        end
        if (!rst_n) begin
            grant_cnt     = 0;
            last_gnt_addr = 16'hFFFF;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect && !hlt_seen) begin
            check_eq("sb_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0)
                check_eq("stream", {instr, instr_pc}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [15:0] start_pc, input int n);
        logic [15:0] pc;
        logic [15:0] d;
        pc = start_pc;
        for (int i = 0; i < n; i++) begin
            d = pc + 16'h1000;
            exp_q.push_back({d, pc});
            pc = pc + 16'd1;
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        instr_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 300) begin
            step();
            cyc++;
        end
        instr_ready = 1'b0;
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic pulse_redirect(input logic [15:0] pc);
        redirect_pc = pc;
        redirect    = 1'b1;
        step();
        redirect    = 1'b0;
    endtask

    task automatic wait_gnt_addr(input logic [15:0] a);
        int cyc;
        cyc = 0;
        while (last_gnt_addr != a && cyc < 100) begin
            step();
            cyc++;
        end
        check_eq("grant_addr", {16'b0, last_gnt_addr}, {16'b0, a});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int g;
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        hlt_seen    = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_mem_req",     {31'b0, mem_req},     32'd0);
        check_eq("rst_mem_addr",    {16'b0, mem_addr},    32'd0);
        check_eq("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check_eq("rst_instr",       {16'b0, instr},       32'd0);
        check_eq("rst_instr_pc",    {16'b0, instr_pc},    32'd0);
        check_eq("rst_halted",      {31'b0, halted},      32'd0);
        step();
        rst_n = 1'b1;

        // Backpressure: exactly DEPTH words fetched, then fetching stops.
        repeat (20) step();
        @(negedge clk);
        check_eq("bp_grants",  32'(grant_cnt),        32'd4);
        check_eq("bp_mem_req", {31'b0, mem_req},      32'd0);
        check_eq("bp_valid",   {31'b0, instr_valid},  32'd1);
        check_eq("bp_head",    {instr, instr_pc},     32'h1000_0000);
        step();
        // Resume: in-order stream 0x1000.. with no loss or duplication.
        expect_seq(16'h0000, 12);
        drain();

        // Redirect while WAIT with one word queued.
        rst_n = 1'b0;
        step();
        rd_lat = 3;
        rst_n  = 1'b1;
        wait_gnt_addr(16'h0001);
        check_eq("pre_flush_valid", {31'b0, instr_valid}, 32'd1);
        pulse_redirect(16'h0040);
        @(negedge clk);
        check_eq("flush_valid", {31'b0, instr_valid}, 32'd0);
        step();
        expect_seq(16'h0040, 6);
        drain();

        // Address wrap 0xFFFF -> 0x0000.
        pulse_redirect(16'hFFFE);
        expect_seq(16'hFFFE, 4);
        drain();

        // HLT with two words queued and a return coincident.
        rd_lat = 1;
        pulse_redirect(16'h0100);
        wait_gnt_addr(16'h0102);
        check_eq("hlt_pre_valid", {31'b0, instr_valid}, 32'd1);
        hlt_seen = 1'b1;
        step();
        hlt_seen = 1'b0;
        @(negedge clk);
        check_eq("hlt_valid",   {31'b0, instr_valid}, 32'd0);
        check_eq("hlt_halted",  {31'b0, halted},      32'd1);
        check_eq("hlt_mem_req", {31'b0, mem_req},     32'd0);
        g = grant_cnt;
        repeat (10) step();
        pulse_redirect(16'h0200);
        instr_ready = 1'b1;
        repeat (10) step();
        instr_ready = 1'b0;
        @(negedge clk);
        check_eq("halt_hold_halted",  {31'b0, halted},      32'd1);
        check_eq("halt_hold_mem_req", {31'b0, mem_req},     32'd0);
        check_eq("halt_hold_valid",   {31'b0, instr_valid}, 32'd0);
        check_eq("halt_hold_grants",  32'(grant_cnt),       32'(g));
        step();

        // Asynchronous reset out of HALT, then mid-WAIT.
        rst_n = 1'b0;
        #1;
        check_eq("arst_halted", {31'b0, halted}, 32'd0);
        step();
        rd_lat = 4;
        rst_n  = 1'b1;
        wait_gnt_addr(16'h0001);
        check_eq("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid",    {31'b0, instr_valid}, 32'd0);
        check_eq("arst_instr",    {16'b0, instr},       32'd0);
        check_eq("arst_instr_pc", {16'b0, instr_pc},    32'd0);
        check_eq("arst_mem_addr", {16'b0, mem_addr},    32'd0);
        check_eq("arst_mem_req",  {31'b0, mem_req},     32'd0);
        step();
        step();
        rst_n = 1'b1;
        expect_seq(16'h0000, 4);
        drain();

`ifdef FETCH_PERF_EN
        // Three redirects, each with a non-empty queue.
        @(negedge clk);
        check_eq("perf_flush0", {16'b0, flush_cnt}, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            repeat (12) step();
            pulse_redirect(16'h0300 + 16'(i * 16));
        end
        @(negedge clk);
        check_eq("perf_flush3", {16'b0, flush_cnt}, 32'd3);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("perf_rst_flush", {16'b0, flush_cnt}, 32'd0);
        check_eq("perf_rst_stall", {16'b0, stall_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("perf_stall3", {16'b0, stall_cnt}, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
